// File: rtl/ssd1306_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ssd1306_pkg
//  Description : Shared definitions for the SSD1306 I2C link: responder FSM
//                state encoding, command opcodes, control-byte bit positions
//                and default bus address / panel geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package ssd1306_pkg;

    // Responder byte-level FSM states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_CTRL    = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_IGNORE  = 3'd4
    } state_t;

    // Command opcodes with side effects in the responder
    localparam logic [7:0] c_CMD_COL_ADDR  = 8'h21;
    localparam logic [7:0] c_CMD_PAGE_ADDR = 8'h22;
    localparam logic [7:0] c_CMD_DISP_OFF  = 8'hAE;
    localparam logic [7:0] c_CMD_DISP_ON   = 8'hAF;

    // Control byte: Co = continuation, D/C# = data (1) or command (0)
    localparam int c_CTRL_CO_BIT = 7;
    localparam int c_CTRL_DC_BIT = 6;

    localparam logic [6:0] c_DEF_I2C_ADDR = 7'h3C;
    localparam int         c_DEF_NCOL     = 128;

endpackage : ssd1306_pkg
`default_nettype wire

// File: rtl/i2c_bus_sense.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_bus_sense
//  Description : Two-flop synchronisers for SCL/SDA plus a previous-value
//                stage; produces single-cycle START, STOP, SCL-rise and
//                SCL-fall pulses from the synchronised samples.
//  Ports       : clk, reset     - system clock, synchronous active-high reset
//                i_scl, i_sda   - raw bus lines
//                o_sda          - synchronised SDA (sampled on o_scl_rise)
//                o_start/o_stop - bus condition pulses
//                o_scl_rise/o_scl_fall - SCL edge pulses
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_bus_sense (
    input  logic clk,
    input  logic reset,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_start,
    output logic o_stop,
    output logic o_scl_rise,
    output logic o_scl_fall
);

    logic r_scl_meta, r_scl_sync, r_scl_prev;
    logic r_sda_meta, r_sda_sync, r_sda_prev;

    // Reset to the idle-bus level so no spurious edge is seen on release
    always_ff @(posedge clk) begin
        if (reset) begin
            r_scl_meta <= 1'b1;
            r_scl_sync <= 1'b1;
            r_scl_prev <= 1'b1;
            r_sda_meta <= 1'b1;
            r_sda_sync <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_meta <= i_scl;
            r_scl_sync <= r_scl_meta;
            r_scl_prev <= r_scl_sync;
            r_sda_meta <= i_sda;
            r_sda_sync <= r_sda_meta;
            r_sda_prev <= r_sda_sync;
        end
    end

    assign o_sda      = r_sda_sync;
    // SCL must be high both before and after the SDA transition
    assign o_start    = r_scl_sync & r_scl_prev &  r_sda_prev & ~r_sda_sync;
    assign o_stop     = r_scl_sync & r_scl_prev & ~r_sda_prev &  r_sda_sync;
    assign o_scl_rise =  r_scl_sync & ~r_scl_prev;
    assign o_scl_fall = ~r_scl_sync &  r_scl_prev;

endmodule : i2c_bus_sense
`default_nettype wire

// File: rtl/ssd1306_i2c_responder.sv
`default_nettype none
// ============================================================================
//  Module      : ssd1306_i2c_responder
//  Description : I2C write-only target modelling an SSD1306 panel. Decodes
//                address / control / payload bytes, ACKs them, strobes
//                command bytes, tracks the 0x21/0x22 window and writes data
//                bytes to an external frame buffer in horizontal mode.
//  Ports       : clk, reset            - clock, synchronous active-high reset
//                scl, sda_in, sda_oe   - bus in, open-drain SDA pull-down
//                cmd_valid, cmd_byte   - command byte strobe
//                fb_we, fb_addr, fb_wdata - frame-buffer write port
//                display_on, busy      - status
//  Revision    : 1.0 - initial release
// ============================================================================
module ssd1306_i2c_responder
    import ssd1306_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR = c_DEF_I2C_ADDR,
    parameter int         FB_AW    = 9,
    parameter int         NCOL     = c_DEF_NCOL
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             scl,
    input  logic             sda_in,
    output logic             sda_oe,
    output logic             cmd_valid,
    output logic [7:0]       cmd_byte,
    output logic             fb_we,
    output logic [FB_AW-1:0] fb_addr,
    output logic [7:0]       fb_wdata,
    output logic             display_on,
    output logic             busy
);

    logic w_sda, w_start, w_stop, w_scl_rise, w_scl_fall;

    i2c_bus_sense u_sense (
        .clk        (clk),
        .reset      (reset),
        .i_scl      (scl),
        .i_sda      (sda_in),
        .o_sda      (w_sda),
        .o_start    (w_start),
        .o_stop     (w_stop),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall)
    );

    state_t     r_state;
    logic [6:0] r_shift;        // first seven bits of the byte in flight
    logic [3:0] r_bitcnt;       // 0..8; 8 = byte complete, in ACK slot
    logic       r_ack_phase;    // ACK driven, waiting for the 9th SCL fall
    logic       r_accept;
    logic       r_co, r_dc;
    logic [1:0] r_param_cnt;    // parameter bytes still expected
    logic       r_param_page;   // 1 = parameters belong to 0x22
    logic [6:0] r_param0;
    logic [6:0] r_col, r_col_start, r_col_end;
    logic [1:0] r_page, r_page_start, r_page_end;

    logic [7:0]       w_byte;
    logic [FB_AW-1:0] w_ptr;

    assign w_byte = {r_shift, w_sda};
    assign w_ptr  = FB_AW'(r_page) * FB_AW'(NCOL) + FB_AW'(r_col);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_bitcnt     <= '0;
            r_ack_phase  <= 1'b0;
            r_accept     <= 1'b0;
            r_co         <= 1'b0;
            r_dc         <= 1'b0;
            r_param_cnt  <= '0;
            r_param_page <= 1'b0;
            r_param0     <= '0;
            r_col        <= '0;
            r_col_start  <= '0;
            r_col_end    <= 7'd127;
            r_page       <= '0;
            r_page_start <= '0;
            r_page_end   <= 2'd3;
            sda_oe       <= 1'b0;
            cmd_valid    <= 1'b0;
            cmd_byte     <= '0;
            fb_we        <= 1'b0;
            fb_addr      <= '0;
            fb_wdata     <= '0;
            display_on   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            fb_we     <= 1'b0;

            if (w_start) begin
                // Also covers repeated START in the middle of an ACK slot
                r_state     <= ST_ADDR;
                r_bitcnt    <= '0;
                r_ack_phase <= 1'b0;
                sda_oe      <= 1'b0;
            end else if (w_stop) begin
                // Partial byte is dropped; pending parameter count survives
                r_state     <= ST_IDLE;
                r_bitcnt    <= '0;
                r_ack_phase <= 1'b0;
                sda_oe      <= 1'b0;
                busy        <= 1'b0;
            end else if (r_state inside {ST_ADDR, ST_CTRL, ST_PAYLOAD}) begin
                if (w_scl_rise && r_bitcnt < 4'd8) begin
                    r_shift  <= w_byte[6:0];
                    r_bitcnt <= r_bitcnt + 4'd1;
                    if (r_bitcnt == 4'd7) begin
                        case (r_state)
                            ST_ADDR: begin
                                if (w_byte[7:1] == I2C_ADDR && !w_byte[0]) begin
                                    r_accept <= 1'b1;
                                    busy     <= 1'b1;
                                    r_state  <= ST_CTRL;
                                end else begin
                                    r_accept <= 1'b0;
                                    r_state  <= ST_IGNORE;
                                end
                            end
                            ST_CTRL: begin
                                r_accept <= 1'b1;
                                r_co     <= w_byte[c_CTRL_CO_BIT];
                                r_dc     <= w_byte[c_CTRL_DC_BIT];
                                r_state  <= ST_PAYLOAD;
                            end
                            ST_PAYLOAD: begin
                                r_accept <= 1'b1;
                                if (r_co) begin
                                    r_state <= ST_CTRL;
                                end
                                if (r_dc) begin
                                    fb_we    <= 1'b1;
                                    fb_addr  <= w_ptr;
                                    fb_wdata <= w_byte;
                                    // Horizontal addressing inside the window
                                    if (r_col == r_col_end) begin
                                        r_col  <= r_col_start;
                                        r_page <= (r_page == r_page_end) ?
                                                  r_page_start : r_page + 2'd1;
                                    end else begin
                                        r_col <= r_col + 7'd1;
                                    end
                                end else begin
                                    cmd_valid <= 1'b1;
                                    cmd_byte  <= w_byte;
                                    if (r_param_cnt == 2'd2) begin
                                        r_param0    <= w_byte[6:0];
                                        r_param_cnt <= 2'd1;
                                    end else if (r_param_cnt == 2'd1) begin
                                        r_param_cnt <= 2'd0;
                                        if (r_param_page) begin
                                            r_page_start <= r_param0[1:0];
                                            r_page_end   <= w_byte[1:0];
                                            r_page       <= r_param0[1:0];
                                            r_col        <= r_col_start;
                                        end else begin
                                            r_col_start <= r_param0;
                                            r_col_end   <= w_byte[6:0];
                                            r_col       <= r_param0;
                                            r_page      <= r_page_start;
                                        end
                                    end else begin
                                        case (w_byte)
                                            c_CMD_COL_ADDR: begin
                                                r_param_cnt  <= 2'd2;
                                                r_param_page <= 1'b0;
                                            end
                                            c_CMD_PAGE_ADDR: begin
                                                r_param_cnt  <= 2'd2;
                                                r_param_page <= 1'b1;
                                            end
                                            c_CMD_DISP_ON:  display_on <= 1'b1;
                                            c_CMD_DISP_OFF: display_on <= 1'b0;
                                            default: ;
                                        endcase
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                end else if (w_scl_fall) begin
                    if (r_ack_phase) begin
                        // End of the 9th clock: release and start next byte
                        sda_oe      <= 1'b0;
                        r_ack_phase <= 1'b0;
                        r_bitcnt    <= '0;
                    end else if (r_bitcnt == 4'd8) begin
                        sda_oe      <= r_accept;
                        r_ack_phase <= 1'b1;
                    end
                end
            end
        end
    end

endmodule : ssd1306_i2c_responder
`default_nettype wire

// File: tb/tb_ssd1306_i2c_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_ssd1306_i2c_responder
//  Description : Self-checking bench. Drives I2C frames (directed and
//                random) and compares strobes, ACKs and status against a
//                transaction-level panel model held in the bench.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ssd1306_i2c_responder;

    localparam int Q = 20;   // quarter SCL period in ns (two clk cycles)

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       r_scl = 1'b1;
    logic       r_sda = 1'b1;
    logic       w_sda_bus;
    logic       sda_oe, cmd_valid, fb_we, display_on, busy;
    logic [7:0] cmd_byte, fb_wdata;
    logic [8:0] fb_addr;

    assign w_sda_bus = r_sda & ~sda_oe;   // open-drain wired-AND

    always #5 clk = ~clk;

    ssd1306_i2c_responder #(.I2C_ADDR(7'h3C), .FB_AW(9), .NCOL(128)) dut (
        .clk        (clk),
        .reset      (reset),
        .scl        (r_scl),
        .sda_in     (w_sda_bus),
        .sda_oe     (sda_oe),
        .cmd_valid  (cmd_valid),
        .cmd_byte   (cmd_byte),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_wdata   (fb_wdata),
        .display_on (display_on),
        .busy       (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- panel model ----------------
    int m_cs, m_ce, m_ps, m_pe, m_col, m_pg, m_pcnt, m_ppage, m_p0;
    bit m_disp, m_busy, m_ignore;
    logic [7:0]  exp_cmd[$];
    logic [16:0] exp_wr[$];
    logic [7:0]  obs_cmd[$];
    logic [8:0]  obs_addr[$];
    logic [7:0]  obs_data[$];

    task automatic model_reset();
        m_cs = 0; m_ce = 127; m_ps = 0; m_pe = 3; m_col = 0; m_pg = 0;
        m_pcnt = 0; m_ppage = 0; m_p0 = 0;
        m_disp = 0; m_busy = 0; m_ignore = 0;
    endtask

    task automatic model_cmd(input logic [7:0] b);
        exp_cmd.push_back(b);
        if (m_pcnt == 2) begin
            m_p0 = b; m_pcnt = 1;
        end else if (m_pcnt == 1) begin
            m_pcnt = 0;
            if (m_ppage != 0) begin m_ps = m_p0 % 4;   m_pe = b % 4;   end
            else              begin m_cs = m_p0 % 128; m_ce = b % 128; end
            m_col = m_cs; m_pg = m_ps;
        end else if (b == 8'h21) begin m_pcnt = 2; m_ppage = 0;
        end else if (b == 8'h22) begin m_pcnt = 2; m_ppage = 1;
        end else if (b == 8'hAF) m_disp = 1;
        else if (b == 8'hAE) m_disp = 0;
    endtask

    task automatic model_data(input logic [7:0] b);
        exp_wr.push_back({9'(m_pg * 128 + m_col), b});
        if (m_col == m_ce) begin
            m_col = m_cs;
            m_pg  = (m_pg == m_pe) ? m_ps : (m_pg + 1) % 4;
        end else begin
            m_col = (m_col + 1) % 128;
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!reset) begin
            if (cmd_valid) begin
                obs_cmd.push_back(cmd_byte);
                if (exp_cmd.size() == 0) begin
                    n_checks++;
                    $display("FAIL cmd_unexpected: got %0h expected none", cmd_byte);
                end else check("cmd_byte", cmd_byte, exp_cmd.pop_front());
            end
            if (fb_we) begin
                obs_addr.push_back(fb_addr);
                obs_data.push_back(fb_wdata);
                if (exp_wr.size() == 0) begin
                    n_checks++;
                    $display("FAIL fb_unexpected: got %0h/%0h expected none", fb_addr, fb_wdata);
                end else check("fb_write", {fb_addr, fb_wdata}, exp_wr.pop_front());
            end
            if (m_ignore) check("oe_ignore", sda_oe, 0);
        end
    end

    // ---------------- bus driver ----------------
    task automatic i2c_start();
        r_scl = 0; r_sda = 1; #Q;
        r_scl = 1; #Q;
        r_sda = 0; #Q;
        m_ignore = 0;
        r_scl = 0; #Q;
    endtask

    task automatic i2c_stop();
        r_scl = 0; r_sda = 0; #Q;
        r_scl = 1; #Q;
        r_sda = 1; #Q;
        m_busy = 0; m_ignore = 0;
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            r_sda = b[i]; #Q;
            r_scl = 1; #(2*Q);
            r_scl = 0; #Q;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit exp_ack, input string nm);
        send_bits(b, 8);
        r_sda = 1; #Q;
        r_scl = 1; #Q;
        check(nm, sda_oe, exp_ack);
        #Q; r_scl = 0; #Q;
    endtask

    task automatic run_frame(input logic [7:0] q[$]);
        int  ph;
        bit  co, dc, acc;
        ph = 0; co = 0; dc = 0;
        i2c_start();
        foreach (q[i]) begin
            case (ph)
                0: begin
                    acc = (q[i][7:1] == 7'h3C) && !q[i][0];
                    if (acc) m_busy = 1;
                    m_ignore = !acc;
                    send_byte(q[i], acc, "addr_ack");
                    check("busy_after_addr", busy, m_busy);
                    ph = acc ? 1 : 3;
                end
                1: begin
                    co = q[i][7]; dc = q[i][6];
                    send_byte(q[i], 1, "ctrl_ack");
                    ph = 2;
                end
                2: begin
                    if (dc) model_data(q[i]); else model_cmd(q[i]);
                    send_byte(q[i], 1, "payload_ack");
                    if (co) ph = 1;
                end
                default: send_byte(q[i], 0, "ignored_ack");
            endcase
        end
        i2c_stop();
        repeat (6) @(negedge clk);
        check("busy_after_stop", busy, 0);
        check("display_on", display_on, m_disp);
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] fq[$];
    logic [8:0] lit [5] = '{9'h110, 9'h111, 9'h190, 9'h191, 9'h110};
    logic [7:0] pool [6] = '{8'h21, 8'h22, 8'hAE, 8'hAF, 8'h8D, 8'h00};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (4) @(negedge clk);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_display", display_on, 0);
        reset = 0;
        repeat (4) @(negedge clk);

        // 1: display off command
        fq = '{8'h78, 8'h00, 8'hAE};
        run_frame(fq);
        check("t1_cmd_count", obs_cmd.size(), 1);
        check("t1_cmd_value", obs_cmd[0], 8'hAE);
        check("t1_display", display_on, 0);

        // 2: wrong address, rest of frame ignored
        obs_cmd.delete();
        fq = '{8'h7A, 8'h00, 8'hAF};
        run_frame(fq);
        check("t2_no_cmd", obs_cmd.size(), 0);
        check("t2_no_fb", obs_addr.size(), 0);

        // 3: Co=1 command then data
        fq = '{8'h78, 8'h80, 8'hAF, 8'h40, 8'h55};
        run_frame(fq);
        check("t3_cmd_value", obs_cmd[0], 8'hAF);
        check("t3_display", display_on, 1);
        check("t3_fb_addr", obs_addr[0], 9'h000);
        check("t3_fb_data", obs_data[0], 8'h55);

        // 4: window commands then five data bytes
        fq = '{8'h78, 8'h00, 8'h21, 8'h10, 8'h11, 8'h22, 8'h02, 8'h03};
        run_frame(fq);
        obs_addr.delete(); obs_data.delete();
        fq = '{8'h78, 8'h40, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        run_frame(fq);
        for (int i = 0; i < 5; i++) check("t4_addr_seq", obs_addr[i], lit[i]);

        // 6: reset in the middle of a data byte
        i2c_start();
        m_busy = 1;
        send_byte(8'h78, 1, "t6_addr_ack");
        send_byte(8'h40, 1, "t6_ctrl_ack");
        send_bits(8'hC3, 4);
        reset = 1;
        repeat (3) @(negedge clk);
        check("t6_sda_oe", sda_oe, 0);
        check("t6_cmd_valid", cmd_valid, 0);
        check("t6_cmd_byte", cmd_byte, 0);
        check("t6_fb_we", fb_we, 0);
        check("t6_fb_addr", fb_addr, 0);
        check("t6_fb_wdata", fb_wdata, 0);
        check("t6_display", display_on, 0);
        check("t6_busy", busy, 0);
        model_reset();
        reset = 0;
        r_sda = 1; #Q; r_scl = 1; #(2*Q);

        // 5: full-screen burst plus one wrapping byte
        obs_addr.delete(); obs_data.delete();
        fq = '{8'h78, 8'h40};
        for (int i = 0; i < 513; i++) fq.push_back(8'($urandom));
        run_frame(fq);
        check("t5_count", obs_addr.size(), 513);
        check("t5_first", obs_addr[0], 9'd0);
        check("t5_last", obs_addr[511], 9'd511);
        check("t5_wrap", obs_addr[512], 9'd0);

        // random frames
        for (int f = 0; f < 15; f++) begin
            logic [7:0] a;
            int nseg;
            fq.delete();
            a = 8'h78;
            if ($urandom_range(0, 7) == 0) begin
                a = 8'($urandom);
                if (a == 8'h78) a = 8'h79;
            end
            fq.push_back(a);
            nseg = $urandom_range(1, 3);
            for (int s = 0; s < nseg; s++) begin
                bit co, dc;
                int n;
                co = 1'($urandom);
                dc = 1'($urandom);
                fq.push_back({co, dc, 6'($urandom)});
                n = co ? 1 : $urandom_range(1, 4);
                for (int k = 0; k < n; k++)
                    fq.push_back(dc ? 8'($urandom) : pool[$urandom_range(0, 5)]);
            end
            run_frame(fq);
        end

        repeat (10) @(negedge clk);
        check("exp_cmd_drained", exp_cmd.size(), 0);
        check("exp_wr_drained", exp_wr.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_ssd1306_i2c_responder
`default_nettype wire

// File: doc/ssd1306_i2c_responder.md
Name: ssd1306_i2c_responder

Overview:
- I2C target (slave) that behaves as the SSD1306 panel at the far end of the OLED link.
- Used in simulation and on-board loopback to check the OLED master path.
- Decodes address byte, control byte (Co, D/C#) and payload bytes, and ACKs correctly.
- Emits command bytes on a strobe port and writes GDDRAM data bytes into an external 512x8 frame buffer, honouring the 0x21/0x22 window commands.

Parameters:
- I2C_ADDR, 7'h3C, 7-bit target address answered.
- FB_AW, 9, frame-buffer address width (128 columns x 4 pages).
- NCOL, 128, columns per page.

Ports:
- clk  in  1  system clock; SCL/SDA are oversampled on it.
- reset  in  1  synchronous, active-high reset.
- scl  in  1  I2C clock from the bus.
- sda_in  in  1  SDA as read from the bus.
- sda_oe  out  1  1 = pull SDA low (open-drain ACK); 0 = release.
- cmd_valid  out  1  one-cycle strobe: command byte received.
- cmd_byte  out  8  command byte, valid with cmd_valid.
- fb_we  out  1  one-cycle frame-buffer write strobe.
- fb_addr  out  FB_AW  write address = page*NCOL + column.
- fb_wdata  out  8  data byte.
- display_on  out  1  set by command 0xAF, cleared by 0xAE.
- busy  out  1  high from a START addressed to us until STOP.

Behaviour:
- Input sync:
  - scl and sda_in pass through 2-FF synchronisers plus a previous-value register.
  - Edges are detected on synchronised values; all protocol latencies are counted from the synchronised edge.
- Bus conditions:
  - START = SDA falling while SCL high.
  - STOP = SDA rising while SCL high.
  - Either condition is recognised in any state.
  - START (including repeated START) goes to ADDR with bit counter cleared.
  - STOP goes to IDLE, releases sda_oe and clears busy.
- Bit transfer:
  - Sample SDA on the SCL rising edge, MSB first, into a shift register.
  - The 8th rising edge completes a byte.
- ACK:
  - On the SCL falling edge after the 8th bit, set sda_oe=1 if the byte is accepted.
  - Hold it through the 9th clock; clear it on the next SCL falling edge.
  - NACK = keep sda_oe=0.
- States:
  - IDLE: wait for START.
  - ADDR: receive byte. If {byte[7:1]==I2C_ADDR, byte[0]==0}: ACK, set busy, go to CTRL. Otherwise NACK and go to IGNORE (reads are unsupported).
  - CTRL: receive control byte, ACK. Latch co=bit7 and dc=bit6. Go to PAYLOAD.
  - PAYLOAD: receive byte, ACK. Dispatch it one clk after the 8th rising edge. Then go to CTRL if co=1, else stay in PAYLOAD until STOP.
  - IGNORE: wait for START or STOP; never drives SDA.
- Dispatch:
  - dc=0: cmd_valid=1 and cmd_byte=byte for one cycle; the byte also goes to the command parser.
  - dc=1: fb_we=1, fb_addr=pointer, fb_wdata=byte for one cycle; then advance the pointer.
- Command parser:
  - 0x21 expects 2 parameter bytes: col_start, col_end (7-bit).
  - 0x22 expects 2 parameter bytes: page_start, page_end (2-bit, upper bits ignored).
  - Parameter bytes are still strobed on cmd_valid.
  - After the last parameter, reset the pointer to (page_start, col_start).
  - 0xAF sets display_on; 0xAE clears it.
  - All other commands are only strobed.
- Pointer (horizontal mode):
  - col++. If col==col_end: col=col_start, page++.
  - If page==page_end too: page=page_start (wrap to window origin).
  - Reset window is 0..127 x 0..3, pointer 0.
- Reset (synchronous, any time, including mid-byte):
  - All outputs 0.
  - State IDLE, window full, parameter counter cleared.
  - A transfer in progress is abandoned; the next START is needed.
- Corner cases:
  - STOP mid-byte: discard partial byte, no dispatch.
  - STOP while waiting for parameters: keep the pending parameter count (SSD1306 semantics).
  - START during ACK: release sda_oe immediately.

Decomposition:
- Shared package ssd1306_pkg:
  - State encoding.
  - Command constants: 0x21, 0x22, 0xAE, 0xAF.
  - Control-byte bit positions: CO=7, DC=6.
  - I2C_ADDR default 7'h3C, NCOL.
  - Shared with the master sequencer.
- One natural sub-module, i2c_bus_sense: synchronisers plus start/stop/scl_rise/scl_fall pulse generation.
- The byte/ACK FSM, command parser and pointer stay in the top module.

Test Plan:
- START, 0x78, 0x00, 0xAE, STOP -> ACK on all three bytes; cmd_valid once with 0xAE; display_on stays 0; busy drops after STOP.
- START, 0x7A (wrong address) -> NACK; sda_oe never 1 until the next START; no strobes.
- START, 0x78, 0x80, 0xAF, 0x40, 0x55, STOP (Co=1 then data) -> cmd 0xAF, display_on=1, then fb_we with addr 0, data 0x55.
- START, 0x78, 0x00, 0x21, 0x10, 0x11, 0x22, 0x02, 0x03, STOP; then START, 0x78, 0x40, five data bytes -> fb_addr sequence 0x110, 0x111, 0x190, 0x191, 0x110.
- 512 data bytes after reset in one Co=0 burst -> addresses 0..511; byte 513 writes address 0.
- Reset asserted after 4 bits of a data byte -> all outputs 0; the following complete frame is accepted normally.
